// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M/RV64M multiply/divide unit with valid/ready handshake
module alu_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inValid,
   output logic            inReady,
   input  logic [XLEN-1:0] opA,
   input  logic [XLEN-1:0] opB,
   input  logic [2:0]      mdOp,
   output logic            outValid,
   input  logic            outReady,
   output logic [XLEN-1:0] mdOut,
   output logic            busy
);
   localparam int CW = $clog2(XLEN) + 1;
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t state;
   logic [XLEN-1:0] opnd;
   logic [2*XLEN-1:0] prod;
   logic [CW-1:0] cnt;
   logic [2:0] op;
   logic neg_q, neg_r;
   logic sgn_a, sgn_b, s_a, s_b, div0, ovf, last;
   logic [XLEN-1:0] mag_a, mag_b, spec_out, mul_res, div_res, q, r, q_neg, r_neg;
   logic [XLEN:0] mul_sum, div_r, div_d;
   logic [2*XLEN-1:0] mul_nxt, mul_p, div_nxt;
   always_comb begin
      sgn_a = mdOp[2] ? ~mdOp[0] : (mdOp[1:0] == 2'b01 || mdOp[1:0] == 2'b10);
      sgn_b = (mdOp == 3'b001) || (mdOp == 3'b100) || (mdOp == 3'b110);
      s_a = sgn_a & opA[XLEN-1];
      s_b = sgn_b & opB[XLEN-1];
      mag_a = s_a ? -opA : opA;
      mag_b = s_b ? -opB : opB;
      div0 = mdOp[2] && (opB == '0);
      ovf = mdOp[2] && !mdOp[0] && (opA == {1'b1, {(XLEN-1){1'b0}}}) && (&opB);
      spec_out = div0 ? (mdOp[1] ? opA : '1) : (mdOp[1] ? '0 : opA);
      mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
      mul_nxt = {mul_sum, prod[XLEN-1:1]};
      mul_p = neg_q ? -mul_nxt : mul_nxt;
      mul_res = (op == 3'b000) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
      div_r = prod[2*XLEN-1:XLEN-1];
      div_d = div_r - {1'b0, opnd};
      div_nxt = div_d[XLEN] ? {div_r[XLEN-1:0], prod[XLEN-2:0], 1'b0}
                            : {div_d[XLEN-1:0], prod[XLEN-2:0], 1'b1};
      q = div_nxt[XLEN-1:0];
      r = div_nxt[2*XLEN-1:XLEN];
      q_neg = -q;
      r_neg = -r;
      div_res = op[1] ? (neg_r ? r_neg : r) : (neg_q ? q_neg : q);
      last = (cnt == CW'(XLEN-1));
   end
   assign inReady = (state == IDLE);
   assign outValid = (state == DONE);
   assign busy = (state != IDLE);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         opnd <= '0;
         prod <= '0;
         cnt <= '0;
         op <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         mdOut <= '0;
      end else begin
         case (state)
            IDLE: if (inValid) begin
               op <= mdOp;
               neg_q <= s_a ^ s_b;
               neg_r <= s_a;
               cnt <= '0;
               if (div0 || ovf) begin
                  mdOut <= spec_out;
                  state <= DONE;
               end else if (mdOp[2]) begin
                  opnd <= mag_b;
                  prod <= {{XLEN{1'b0}}, mag_a};
                  state <= DIV;
               end else begin
                  opnd <= mag_a;
                  prod <= {{XLEN{1'b0}}, mag_b};
                  state <= MUL;
               end
            end
            MUL: begin
               prod <= mul_nxt;
               cnt <= cnt + CW'(1);
               if (last) begin
                  mdOut <= mul_res;
                  state <= DONE;
               end
            end
            DIV: begin
               prod <= div_nxt;
               cnt <= cnt + CW'(1);
               if (last) begin
                  mdOut <= div_res;
                  state <= DONE;
               end
            end
            default: if (outReady) state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed self-checking bench for alu_muldiv at XLEN=32 and XLEN=8
module tb_alu_muldiv;
   logic clk = 1'b0, rst = 1'b1;
   logic inValid = 1'b0, outReady = 1'b0;
   logic [31:0] opA = '0, opB = '0;
   logic [2:0] mdOp = '0;
   logic inReady, outValid, busy;
   logic [31:0] mdOut;
   logic inValid8 = 1'b0, outReady8 = 1'b0;
   logic [7:0] opA8 = '0, opB8 = '0;
   logic [2:0] mdOp8 = '0;
   logic inReady8, outValid8, busy8;
   logic [7:0] mdOut8;
   int n_cmp = 0, n_err = 0;
   always #5 clk = ~clk;
   alu_muldiv #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .opA(opA), .opB(opB),
      .mdOp(mdOp), .outValid(outValid), .outReady(outReady), .mdOut(mdOut), .busy(busy)
   );
   alu_muldiv #(.XLEN(8)) dut8 (
      .clk(clk), .rst(rst), .inValid(inValid8), .inReady(inReady8), .opA(opA8), .opB(opB8),
      .mdOp(mdOp8), .outValid(outValid8), .outReady(outReady8), .mdOut(mdOut8), .busy(busy8)
   );
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] exp,
                        input logic release_it);
      int n;
      logic ir_seen;
      @(negedge clk);
      inValid = 1'b1; opA = a; opB = b; mdOp = op;
      @(posedge clk); #1;
      inValid = 1'b0; opA = ~a; opB = ~b; mdOp = ~op;
      n = 0;
      ir_seen = inReady;
      while (!outValid && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (!outValid) ir_seen |= inReady;
      end
      check({tag, "_lat"}, 64'(n), 64'(lat));
      check({tag, "_inReady"}, 64'(ir_seen), 64'(0));
      check({tag, "_out"}, 64'(mdOut), 64'(exp));
      if (release_it) begin
         @(negedge clk); outReady = 1'b1;
         @(posedge clk); #1; outReady = 1'b0;
      end
   endtask
   task automatic do_op8(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp);
      int n;
      @(negedge clk);
      inValid8 = 1'b1; opA8 = a; opB8 = b; mdOp8 = op;
      @(posedge clk); #1;
      inValid8 = 1'b0;
      n = 0;
      while (!outValid8 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_lat"}, 64'(n), 64'(8));
      check({tag, "_out"}, 64'(mdOut8), 64'(exp));
      @(negedge clk); outReady8 = 1'b1;
      @(posedge clk); #1; outReady8 = 1'b0;
   endtask
   initial begin
      #1;
      check("rst_inReady", 64'(inReady), 64'(1));
      check("rst_outValid", 64'(outValid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_mdOut", 64'(mdOut), 64'(0));
      @(negedge clk); rst = 1'b0;
      do_op("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32, 32'hFFFFFFEB, 1'b1);
      do_op("mulh", 3'b001, 32'h80000000, 32'h80000000, 32, 32'h40000000, 1'b1);
      do_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFE, 1'b1);
      do_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFF, 1'b1);
      do_op("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32, 32'hFFFFFFFD, 1'b1);
      do_op("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32, 32'hFFFFFFFF, 1'b1);
      do_op("divu", 3'b101, 32'hFFFFFFF9, 32'd2, 32, 32'h7FFFFFFC, 1'b1);
      do_op("remu", 3'b111, 32'hFFFFFFF9, 32'd2, 32, 32'd1, 1'b1);
      do_op("div0", 3'b100, 32'd5, 32'd0, 0, 32'hFFFFFFFF, 1'b1);
      do_op("rem0", 3'b110, 32'd5, 32'd0, 0, 32'd5, 1'b1);
      do_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 1'b1);
      do_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 0, 32'd0, 1'b1);
      do_op("bp", 3'b000, 32'd3, 32'd5, 32, 32'd15, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         inValid = i[0]; opA = 32'd100 + 32'(i); opB = 32'd9; mdOp = 3'b000;
         @(posedge clk); #1;
         check("bp_outValid", 64'(outValid), 64'(1));
         check("bp_mdOut", 64'(mdOut), 64'(15));
         check("bp_inReady", 64'(inReady), 64'(0));
      end
      @(negedge clk); inValid = 1'b0; outReady = 1'b1;
      @(posedge clk); #1; outReady = 1'b0;
      check("bp_rel_outValid", 64'(outValid), 64'(0));
      check("bp_rel_inReady", 64'(inReady), 64'(1));
      check("bp_rel_busy", 64'(busy), 64'(0));
      @(negedge clk);
      inValid = 1'b1; opA = 32'd100; opB = 32'd7; mdOp = 3'b100;
      @(posedge clk); #1; inValid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      #1;
      check("arst_outValid", 64'(outValid), 64'(0));
      check("arst_mdOut", 64'(mdOut), 64'(0));
      check("arst_inReady", 64'(inReady), 64'(1));
      @(negedge clk); rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("arst_no_result", 64'(outValid), 64'(0));
      do_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32, 32'd12, 1'b1);
      do_op8("mul8", 3'b000, 8'h7F, 8'h7F, 8'h01);
      do_op8("mulhu8", 3'b011, 8'h7F, 8'h7F, 8'h3F);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
